// File: rtl/regbank_write_arbiter_if.sv
// Writeback request/commit bundle between the ALU/LSU requesters, the write
// arbiter and the register bank write port.
interface regbank_write_arbiter_if #(
   parameter int DATA_W = 32
) ();
   logic              req0_valid;
   logic [3:0]        req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [3:0]        req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              wr_en;
   logic [3:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [15:0]       busy;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      output wr_en, wr_addr, wr_data, busy
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      input  wr_en, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/regbank_write_arbiter.sv
// Two-requester register bank write arbiter: per-requester FIFOs, round-robin
// drain into a registered write stage, plus a per-register busy mask.
// Optional: define REGWR_ZERO_LOCK_EN to make register 0 hardwired zero.
module regbank_write_arbiter #(
   parameter int DATA_W = 32,
   parameter int QDEPTH = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   regbank_write_arbiter_if.slave  bus
);
   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [3:0]        addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem_q    [2][QDEPTH];
   entry_t            mem_d    [2][QDEPTH];
   logic [PW-1:0]     rd_ptr_q [2];
   logic [PW-1:0]     rd_ptr_d [2];
   logic [PW-1:0]     wr_ptr_q [2];
   logic [PW-1:0]     wr_ptr_d [2];
   logic [CW-1:0]     cnt_q    [2];
   logic [CW-1:0]     cnt_d    [2];
   logic              rr_q, rr_d;
   logic              wr_en_q, wr_en_d;
   logic [3:0]        wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;

   logic   req_valid [2];
   entry_t req_entry [2];
   logic   ready     [2];
   logic   push      [2];
   logic   pop       [2];
   logic   nonempty  [2];
   entry_t head      [2];
   logic   grant_vld;
   logic   grant_idx;
   entry_t gnt_entry;
   logic [15:0] busy_c;

   assign req_valid[0] = bus.req0_valid;
   assign req_valid[1] = bus.req1_valid;
   assign req_entry[0] = '{addr: bus.req0_addr, data: bus.req0_data};
   assign req_entry[1] = '{addr: bus.req1_addr, data: bus.req1_data};

   // Arbitration looks only at FIFO heads; a same-cycle push is never granted.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         ready[n]    = (cnt_q[n] != CW'(QDEPTH));
         push[n]     = req_valid[n] && ready[n];
         nonempty[n] = (cnt_q[n] != '0);
         head[n]     = mem_q[n][rd_ptr_q[n]];
      end
      grant_vld = nonempty[0] || nonempty[1];
      grant_idx = (nonempty[0] && nonempty[1]) ? rr_q : nonempty[1];
      pop[0]    = grant_vld && !grant_idx;
      pop[1]    = grant_vld && grant_idx;
      gnt_entry = grant_idx ? head[1] : head[0];
   end

   always_comb begin
      mem_d = mem_q;
      for (int n = 0; n < 2; n++) begin
         rd_ptr_d[n] = rd_ptr_q[n];
         wr_ptr_d[n] = wr_ptr_q[n];
         if (push[n]) begin
            mem_d[n][wr_ptr_q[n]] = req_entry[n];
            wr_ptr_d[n]           = wr_ptr_q[n] + 1'b1;
         end
         if (pop[n])
            rd_ptr_d[n] = rd_ptr_q[n] + 1'b1;
         cnt_d[n] = cnt_q[n] + CW'(push[n]) - CW'(pop[n]);
      end
      rr_d      = grant_vld ? !grant_idx : rr_q;
      wr_addr_d = grant_vld ? gnt_entry.addr : wr_addr_q;
      wr_data_d = grant_vld ? gnt_entry.data : wr_data_q;
`ifdef REGWR_ZERO_LOCK_EN
      // Register 0 entries still burn their slot but never strobe the bank.
      wr_en_d   = grant_vld && (gnt_entry.addr != 4'd0);
`else
      wr_en_d   = grant_vld;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < 2; n++) begin
            rd_ptr_q[n] <= '0;
            wr_ptr_q[n] <= '0;
            cnt_q[n]    <= '0;
            for (int i = 0; i < QDEPTH; i++)
               mem_q[n][i] <= '0;
         end
         rr_q      <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         mem_q     <= mem_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         cnt_q     <= cnt_d;
         rr_q      <= rr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   // Occupied FIFO slots are the count entries starting at the read pointer.
   always_comb begin
      busy_c = '0;
      for (int n = 0; n < 2; n++)
         for (int i = 0; i < QDEPTH; i++)
            if (CW'(i) < cnt_q[n])
               busy_c[mem_q[n][rd_ptr_q[n] + PW'(i)].addr] = 1'b1;
      if (wr_en_q)
         busy_c[wr_addr_q] = 1'b1;
`ifdef REGWR_ZERO_LOCK_EN
      busy_c[0] = 1'b0;
`endif
   end

   assign bus.req0_ready = ready[0];
   assign bus.req1_ready = ready[1];
   assign bus.wr_en      = wr_en_q;
   assign bus.wr_addr    = wr_addr_q;
   assign bus.wr_data    = wr_data_q;
   assign bus.busy       = busy_c;
endmodule
